control_multiplicacion: RTL and testbench

- Sequential shift-and-add multiplier controller that replaces the combinational 4-bit multiplier core with an iterative datapath.
- Accepts operands with a start pulse and runs one partial-product step per clock.
- Returns the truncated product c, overflow flag co and full-width product p with a single-cycle done pulse.
- Sits between the ALU/control logic and any consumer of the multiplication result, so that wider N can be used without a large combinational array.

---
 rtl/control_multiplicacion.sv | 110 +++++++++++
 tb/tb_control_multiplicacion.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/control_multiplicacion.sv
// ============================================================================
// Module   : control_multiplicacion
// Purpose  : Iterative shift-and-add multiplier controller, one partial
//            product per clock, fixed N-cycle latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_multiplicacion #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   c,
  output logic           co,
  output logic [2*N-1:0] p
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [2*N-1:0] r_mcand;
  logic [N-1:0]   r_mplier;
  logic [2*N-1:0] r_acc;
  logic [CW-1:0]  r_count;
  logic [2*N-1:0] r_p;

  logic [2*N-1:0] w_addend;
  logic [2*N-1:0] w_acc_sum;
  logic           w_last_step;

  assign w_addend    = r_mplier[0] ? r_mcand : '0;
  assign w_acc_sum   = r_acc + w_addend;
  assign w_last_step = (r_count == C_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = CALC;
      CALC:    if (w_last_step) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // The final step writes the product straight from the adder so p is valid
  // in the DONE cycle; p is untouched during CALC so the old result holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_p      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand  <= {{N{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
            r_count  <= '0;
          end
        end
        CALC: begin
          r_acc    <= w_acc_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + C_ONE;
          if (w_last_step) begin
            r_p <= w_acc_sum;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state == CALC);
  assign done = (r_state == DONE);
  assign p    = r_p;
  assign c    = r_p[N-1:0];
  assign co   = |r_p[2*N-1:N];

endmodule

`default_nettype wire

// File: tb/tb_control_multiplicacion.sv
// ============================================================================
// Module   : tb_control_multiplicacion
// Purpose  : Directed self-checking bench for control_multiplicacion (N=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_multiplicacion;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [3:0] c;
  logic       co;
  logic [7:0] p;

  int n_checks = 0;
  int n_errors = 0;

  control_multiplicacion #(.N(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .c     (c),
    .co    (co),
    .p     (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Launch one operation, optionally pulse start again mid-CALC, then check
  // latency, result hold while busy, and the final product.
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v,
                        input logic [7:0] ep, input logic [7:0] prev,
                        input bit inject);
    int  nb;
    bit  seen;
    @(negedge clk);
    a = ta; b = tb_v; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~ta; b = ~tb_v;
    nb = 0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      start = 1'b0;
      if (busy) begin
        nb++;
        if (nb == 1) chk("hold_p", {24'd0, p}, {24'd0, prev});
        if (inject && nb == 2) begin
          start = 1'b1; a = 4'hF; b = 4'hF;
        end
      end
      if (done) seen = 1;
      else @(negedge clk);
    end
    start = 1'b0;
    chk("done_seen", {31'd0, seen}, 32'd1);
    chk("busy_cycles", nb, 4);
    chk("p", {24'd0, p}, {24'd0, ep});
    chk("c", {28'd0, c}, {28'd0, ep[3:0]});
    chk("co", {31'd0, co}, {31'd0, |ep[7:4]});
    @(negedge clk);
    chk("done_pulse_end", {31'd0, done}, 32'd0);
    chk("idle_not_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int nd;
    int nbusy;
    int last_done;
    bit bad_overlap;
    bit spacing_ok;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_p", {24'd0, p}, 32'd0);
    chk("rst_co", {31'd0, co}, 32'd0);
    rst_n = 1'b1;

    run_op(4'b1101, 4'b1010, 8'h82, 8'h00, 0);
    run_op(4'b1000, 4'b0010, 8'h10, 8'h82, 0);
    run_op(4'b1001, 4'b0011, 8'h1B, 8'h10, 0);
    run_op(4'b1111, 4'b0011, 8'h2D, 8'h1B, 0);
    run_op(4'b0011, 4'b0001, 8'h03, 8'h2D, 0);
    run_op(4'b1101, 4'b1010, 8'h82, 8'h03, 1);
    repeat (6) @(negedge clk);
    chk("ignored_start_idle", {31'd0, busy}, 32'd0);
    chk("ignored_start_p", {24'd0, p}, 32'h82);
    run_op(4'b1111, 4'b1111, 8'hE1, 8'h82, 0);

    // Abort in the third CALC cycle.
    @(negedge clk);
    a = 4'b1101; b = 4'b1010; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_abort_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_p", {24'd0, p}, 32'd0);
    chk("abort_co", {31'd0, co}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", nd, 0);
    run_op(4'b0000, 4'b0111, 8'h00, 8'h00, 0);

    // Continuous start: one result per N+2 cycles.
    @(negedge clk);
    a = 4'b0010; b = 4'b0011; start = 1'b1;
    nd = 0; nbusy = 0; last_done = -1; bad_overlap = 0; spacing_ok = 1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (busy && done) bad_overlap = 1;
      if (done) begin
        nd++;
        chk("stream_p", {24'd0, p}, 32'h06);
        if (last_done >= 0 && (i - last_done) != 6) spacing_ok = 0;
        last_done = i;
      end
    end
    start = 1'b0;
    chk("stream_done_count", nd, 3);
    chk("stream_spacing", {31'd0, spacing_ok}, 32'd1);
    chk("stream_busy_count", nbusy, 14);
    chk("stream_overlap", {31'd0, bad_overlap}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
